// File: rtl/neuron_mac_16bit.sv
// Sequential multiply-accumulate neuron front end: bias + sum(x*w) over N_INPUTS
// streamed Q8.8 operand pairs, accumulated in Q24.16 and saturated back to Q8.8.
module neuron_mac_16bit #(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 40
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] bias_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] x_in_i,
  input  logic [15:0] w_in_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] sum_out_o,
  output logic        sat_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} state_e;

  localparam logic [7:0]              LAST    = 8'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              count_q, count_d;
  logic [15:0]             sum_q, sum_d;
  logic                    sat_q, sat_d;

  logic signed [15:0]      xSigned, wSigned;
  logic signed [31:0]      product;
  logic signed [ACC_W-1:0] shifted;

  assign xSigned = x_in_i;
  assign wSigned = w_in_i;
  assign product = 32'(xSigned) * 32'(wSigned);
  // Arithmetic shift drops the extra fractional byte, rounding toward -inf
  assign shifted = acc_q >>> 8;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d   = {{(ACC_W-24){bias_i[15]}}, bias_i, 8'h00};
          count_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid_i) begin
          acc_d   = acc_q + {{(ACC_W-32){product[31]}}, product};
          count_d = count_q + 8'd1;
          if (count_q == LAST) state_d = SAT;
        end
      end
      SAT: begin
        if (shifted > SAT_MAX) begin
          sum_d = 16'h7FFF;
          sat_d = 1'b1;
        end else if (shifted < SAT_MIN) begin
          sum_d = 16'h8000;
          sat_d = 1'b1;
        end else begin
          sum_d = shifted[15:0];
          sat_d = 1'b0;
        end
        state_d = OUT;
      end
      OUT: begin
        // The result value is left in place after the handshake; only the flag clears
        if (out_ready_i) begin
          sat_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == ACCUM);
  assign out_valid_o = (state_q == OUT);
  assign busy_o      = (state_q != IDLE);
  assign sum_out_o   = sum_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_neuron_mac_16bit.sv
// Scoreboard bench for neuron_mac_16bit: expected results are queued at start and
// compared when out_valid appears.
module tb_neuron_mac_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bias;
  logic        inValid;
  logic        inReady;
  logic [15:0] xIn, wIn;
  logic        outValid;
  logic        outReady;
  logic [15:0] sumOut;
  logic        sat;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [16:0] expQ[$];
  logic [15:0] xa[4];
  logic [15:0] wa[4];

  neuron_mac_16bit #(.N_INPUTS(4), .ACC_W(40)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bias_i(bias),
    .in_valid_i(inValid), .in_ready_o(inReady), .x_in_i(xIn), .w_in_i(wIn),
    .out_valid_o(outValid), .out_ready_i(outReady), .sum_out_o(sumOut),
    .sat_o(sat), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] b);
    longint acc;
    longint r;
    acc = longint'($signed(b)) * 256;
    for (int i = 0; i < 4; i++)
      acc += longint'($signed(xa[i])) * longint'($signed(wa[i]));
    r = acc >>> 8;
    if (r > 32767) return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  task automatic set_all(input logic [15:0] x, input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      xa[i] = x;
      wa[i] = w;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if ({inReady, outValid, sumOut, sat, busy} !== 20'h0) begin
      bad++;
      $display("[TB] FAIL %s: outputs rdy=%b vld=%b sum=%h sat=%b busy=%b, required all 0",
               tag, inReady, outValid, sumOut, sat, busy);
    end
  endtask

  // One full evaluation using xa/wa; gap = stall cycles between beats,
  // outWait = cycles out_ready stays low, poke = fire ignored start/in_valid in OUT
  task automatic run_eval(input string tag, input logic [15:0] b, input int gap,
                          input int outWait, input bit poke);
    logic [16:0] exp;
    logic [15:0] held;
    int cycles;
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    expQ.push_back(model(b));
    @(negedge clk);
    start = 1'b0;
    bias  = 16'h0;
    total++;
    if (busy !== 1'b1 || inReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s accum-entry: busy=%b in_ready=%b, required 1 1", tag, busy, inReady);
    end
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1;
      xIn = xa[i];
      wIn = wa[i];
      @(negedge clk);
      inValid = 1'b0;
      xIn = 16'h0;
      wIn = 16'h0;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          xIn = 16'hFFFF;
          wIn = 16'h7FFF;
          @(negedge clk);
          total++;
          if (inReady !== 1'b1 || outValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s stall: in_ready=%b out_valid=%b, required 1 0", tag, inReady, outValid);
          end
        end
        xIn = 16'h0;
        wIn = 16'h0;
      end
    end
    total++;
    if (inReady !== 1'b0 || outValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s sat-stage: in_ready=%b out_valid=%b, required 0 0", tag, inReady, outValid);
    end
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (outValid !== 1'b1 && cycles < 8);
    total++;
    if (cycles != 1 || outValid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s latency: out_valid after %0d cycles (valid=%b), required 1", tag, cycles, outValid);
    end
    held = sumOut;
    for (int k = 0; k < outWait; k++) begin
      if (poke) begin
        start   = 1'b1;
        inValid = 1'b1;
        xIn     = 16'h4000;
        wIn     = 16'h4000;
      end
      @(negedge clk);
      total++;
      if (sumOut !== held || outValid !== 1'b1 || inReady !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s hold: sum=%h valid=%b in_ready=%b, required %h 1 0",
                 tag, sumOut, outValid, inReady, held);
      end
    end
    inValid = 1'b0;
    xIn = 16'h0;
    wIn = 16'h0;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s result: scoreboard empty", tag);
    end else begin
      exp = expQ.pop_front();
      if ({sat, sumOut} !== exp) begin
        bad++;
        $display("[TB] FAIL %s result: sum=%h sat=%b, required sum=%h sat=%b",
                 tag, sumOut, sat, exp[15:0], exp[16]);
      end
    end
    outReady = 1'b1;
    if (poke) start = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    start    = 1'b0;
    total++;
    if (outValid !== 1'b0 || sat !== 1'b0 || busy !== 1'b0 || sumOut !== exp[15:0]) begin
      bad++;
      $display("[TB] FAIL %s release: valid=%b sat=%b busy=%b sum=%h, required 0 0 0 %h",
               tag, outValid, sat, busy, sumOut, exp[15:0]);
    end
    if (poke) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s start-during-handshake: busy=%b, required 0", tag, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_all(16'h0200, 16'h0080);
    run_eval("basic", 16'h0100, 0, 0, 1'b0);
    set_all(16'hFF00, 16'h0100);
    run_eval("negative", 16'h0000, 0, 0, 1'b0);
  endtask

  task automatic test_saturation();
    set_all(16'h7FFF, 16'h7FFF);
    run_eval("sat-pos", 16'h7FFF, 0, 0, 1'b0);
    set_all(16'h7FFF, 16'h8000);
    run_eval("sat-neg", 16'h8000, 0, 0, 1'b0);
  endtask

  task automatic test_truncation();
    set_all(16'hFFFF, 16'h0001);
    run_eval("trunc-neg", 16'h0000, 0, 0, 1'b0);
    set_all(16'h0001, 16'h0001);
    run_eval("trunc-pos", 16'h0000, 0, 0, 1'b0);
  endtask

  task automatic test_flow_control();
    set_all(16'h0200, 16'h0080);
    run_eval("flow", 16'h0100, 3, 5, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    bias  = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inValid = 1'b1;
      xIn = 16'h0200;
      wIn = 16'h0080;
      @(negedge clk);
    end
    inValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset-mid");
    @(negedge clk);
    rst_n = 1'b1;
    set_all(16'h0200, 16'h0080);
    run_eval("after-reset", 16'h0100, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] b;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 4; i++) begin
        xa[i] = 16'($urandom);
        wa[i] = 16'($urandom_range(0, 16'hFFFF));
      end
      b = 16'($urandom);
      run_eval("random", b, n % 2, n, 1'b0);
    end
  endtask

  initial begin
    start    = 1'b0;
    bias     = 16'h0;
    inValid  = 1'b0;
    xIn      = 16'h0;
    wIn      = 16'h0;
    outReady = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_truncation();
    test_flow_control();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
